// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction decode with register scoreboard and RAW/WAW stall.
//               The macro WB_BYPASS_EN lets a same-cycle retire unblock issue.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int NREGS = 16,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_op,
    output logic [AW-1:0]    out_rs,
    output logic [AW-1:0]    out_rt,
    output logic [AW-1:0]    out_rd,
    output logic [15:0]      out_imm,
    output logic             out_we,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    output logic             halted,
    output logic [NREGS-1:0] pending
);

    localparam logic [0:0] c_st_run    = 1'b0;
    localparam logic [0:0] c_st_halted = 1'b1;
    localparam logic [3:0] c_op_store  = 4'd14;
    localparam logic [3:0] c_op_halt   = 4'd15;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_chk;

    logic             r_out_valid;
    logic [3:0]       r_op;
    logic [AW-1:0]    r_rs, r_rt, r_rd;
    logic [15:0]      r_imm;
    logic             r_we;

    logic [3:0]       w_op, w_rd, w_rs, w_rt;
    logic             w_is_r, w_is_i, w_is_st;
    logic             w_rd_rs, w_rd_rt, w_rd_rd, w_we;
    logic             w_hz, w_accept;
    logic [15:0]      w_imm;
    logic             w_unused_wb_hi;

    assign w_op = in_instr[15:12];
    assign w_rd = in_instr[11:8];
    assign w_rs = in_instr[7:4];
    assign w_rt = in_instr[3:0];

    assign w_is_r  = (w_op >= 4'd1) && (w_op <= 4'd7);
    assign w_is_i  = (w_op >= 4'd8) && (w_op <= 4'd13);
    assign w_is_st = (w_op == c_op_store);

    assign w_rd_rs = w_is_r | w_is_i | w_is_st;
    assign w_rd_rt = w_is_r;
    assign w_rd_rd = w_is_st;
    assign w_we    = w_is_r | w_is_i;
    assign w_imm   = (w_is_i | w_is_st) ? {{12{in_instr[3]}}, in_instr[3:0]} : 16'h0000;

    // Only the low four bits of wb_rd address the scoreboard.
    assign w_unused_wb_hi = ^wb_rd[AW-1:4];

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_sb
            assign w_clr[i] = wb_valid && (wb_rd[3:0] == 4'(i));
            assign w_set[i] = w_accept && w_we && (w_rd == 4'(i));
        end
    endgenerate

`ifdef WB_BYPASS_EN
    assign w_chk = r_pending & ~w_clr;
`else
    assign w_chk = r_pending;
`endif

    assign w_hz = in_valid & ((w_rd_rs & w_chk[w_rs]) |
                              (w_rd_rt & w_chk[w_rt]) |
                              ((w_rd_rd | w_we) & w_chk[w_rd]));

    assign halted   = (r_state == c_st_halted);
    assign in_ready = !rst & !halted & !w_hz & (!r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_st_run && w_accept && w_op == c_op_halt)
            w_state_nxt = c_st_halted;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_run;
        else     r_state <= w_state_nxt;
    end

    // Set after clear so an issue and a retire of the same register leaves it pending.
    always_ff @(posedge clk) begin
        if (rst) r_pending <= '0;
        else     r_pending <= (r_pending & ~w_clr) | w_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_op        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_we        <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_op        <= w_op;
            r_rs        <= {{(AW-4){1'b0}}, w_rs};
            r_rt        <= w_is_i ? '0 : {{(AW-4){1'b0}}, w_rt};
            r_rd        <= {{(AW-4){1'b0}}, w_rd};
            r_imm       <= w_imm;
            r_we        <= w_we;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_op    = r_op;
    assign out_rs    = r_rs;
    assign out_rt    = r_rt;
    assign out_rd    = r_rd;
    assign out_imm   = r_imm;
    assign out_we    = r_we;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed plus randomized bench for decode_stage against a
//               behavioural model of decode, scoreboard and halt rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    localparam int NREGS = 16;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_op;
    logic [AW-1:0]    out_rs, out_rt, out_rd;
    logic [15:0]      out_imm;
    logic             out_we;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic             halted;
    logic [NREGS-1:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit        m_pend[16];
    bit        m_halted;
    bit        m_ovalid;
    int        m_op, m_rs, m_rt, m_rd, m_imm;
    bit        m_we;

    always #5 clk = ~clk;

    decode_stage #(.NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_imm(out_imm), .out_we(out_we),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .halted(halted), .pending(pending)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pend_vec();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit blocked(input int r, input bit wv, input int wr);
`ifdef WB_BYPASS_EN
        return m_pend[r] && !(wv && wr == r);
`else
        return m_pend[r];
`endif
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_halted = 0; m_ovalid = 0;
        m_op = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_imm = 0; m_we = 0;
    endtask

    // One clock: check registered outputs, drive inputs, check in_ready, advance model.
    task automatic step(input bit r, input bit iv, input logic [15:0] ins,
                        input bit ordy, input bit wv, input logic [4:0] wr);
        int  op, rd, rs, rt, wrl, imm;
        bit  reads_rs, reads_rt, reads_rd, writes, hz, exp_ready, acc;
        @(negedge clk);
        check_val("out_valid", out_valid, m_ovalid);
        check_val("out_op",    out_op,    m_op);
        check_val("out_rs",    out_rs,    m_rs);
        check_val("out_rt",    out_rt,    m_rt);
        check_val("out_rd",    out_rd,    m_rd);
        check_val("out_imm",   out_imm,   m_imm);
        check_val("out_we",    out_we,    m_we);
        check_val("halted",    halted,    m_halted);
        check_val("pending",   pending,   pend_vec());
        rst = r; in_valid = iv; in_instr = ins; out_ready = ordy; wb_valid = wv; wb_rd = wr;
        #1;
        op = int'(ins[15:12]); rd = int'(ins[11:8]); rs = int'(ins[7:4]); rt = int'(ins[3:0]);
        wrl = int'(wr[3:0]);
        reads_rs = (op >= 1 && op <= 14);
        reads_rt = (op >= 1 && op <= 7);
        reads_rd = (op == 14);
        writes   = (op >= 1 && op <= 13);
        hz = iv && ((reads_rs && blocked(rs, wv, wrl)) || (reads_rt && blocked(rt, wv, wrl)) ||
                    ((reads_rd || writes) && blocked(rd, wv, wrl)));
        exp_ready = !r && !m_halted && !hz && (!m_ovalid || ordy);
        check_val("in_ready", in_ready, exp_ready);
        acc = iv && exp_ready;
        imm = rt;
        if (imm >= 8) imm -= 16;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (wv) m_pend[wrl] = 0;
            if (acc && writes) m_pend[rd] = 1;
            if (acc) begin
                m_ovalid = 1;
                m_op = op; m_rs = rs; m_rd = rd; m_we = writes;
                m_rt = (op >= 8 && op <= 13) ? 0 : rt;
                m_imm = (op >= 8 && op <= 14) ? (imm & 16'hFFFF) : 0;
                if (op == 15) m_halted = 1;
            end else if (ordy) begin
                m_ovalid = 0;
            end
        end
    endtask

    initial begin
        logic [15:0] ins;
        model_reset();
        rst = 1; in_valid = 0; in_instr = 0; out_ready = 0; wb_valid = 0; wb_rd = 0;
        @(posedge clk);
        step(1, 0, 16'h0000, 1, 0, 5'd0);
        step(0, 0, 16'h0000, 1, 0, 5'd0);

        // R-type decode and scoreboard set
        step(0, 1, 16'h1123, 1, 0, 5'd0);
        #1;
        check_val("rtype_op", out_op, 4'd1);
        check_val("rtype_pending", pending, 16'h0002);

        // RAW hazard on r1, then retire
        step(0, 1, 16'h2415, 1, 0, 5'd0);
        step(0, 1, 16'h2415, 1, 0, 5'd0);
        step(0, 1, 16'h2415, 1, 1, 5'd1);
        step(0, 1, 16'h2415, 1, 0, 5'd0);
        step(0, 0, 16'h0000, 1, 1, 5'd4);

        // I-type immediates
        step(0, 1, 16'h8A5F, 1, 0, 5'd0);
        #1;
        check_val("itype_imm_neg", out_imm, 16'hFFFF);
        check_val("itype_rt", out_rt, 5'd0);
        check_val("itype_rd", out_rd, 5'd10);
        step(0, 1, 16'h8A57, 1, 1, 5'd10);
        step(0, 1, 16'h8A57, 1, 1, 5'd10);
        #1;
        check_val("itype_imm_pos", out_imm, 16'h0007);

        // Back-pressure for five cycles, then release
        for (int i = 0; i < 5; i++) step(0, 1, 16'h1345, 0, 0, 5'd0);
        step(0, 1, 16'h1345, 1, 1, 5'd10);

        // Drain scoreboard, then issue/retire r3 in one cycle
        for (int i = 0; i < 16; i++) step(0, 0, 16'h0000, 1, 1, 5'(i));
        step(0, 1, 16'h1345, 1, 1, 5'd3);
        #1;
        check_val("set_wins", pending[3], 1'b1);

        // HALT then reset
        step(0, 1, 16'hF000, 1, 0, 5'd0);
        step(0, 1, 16'h0111, 1, 0, 5'd0);
        step(0, 1, 16'h0111, 1, 1, 5'd3);
        #1;
        check_val("halt_sticky", halted, 1'b1);
        step(1, 1, 16'h0111, 1, 0, 5'd0);
        #1;
        check_val("rst_halted", halted, 1'b0);
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_pending", pending, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF && ($urandom % 4) != 0) ins[15:12] = 4'h1;
            step(($urandom % 60) == 0, ($urandom % 4) != 0, ins, ($urandom % 4) != 0,
                 ($urandom % 2) == 0, 5'($urandom));
        end
        step(0, 0, 16'h0000, 1, 0, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
